forward_propper: RTL
====================

# forward_propper

Serial forward-pass neuron for the real-valued network model. It accumulates a bias plus N input·weight products streamed over a valid/ready handshake, then applies the logistic sigmoid. The registered axon value is presented on a valid/ready output. It is the forward-direction counterpart of the per-connection back-propagation cells: the axon it produces is the value those cells consume in the backward pass.

## Interface
- N_INPUTS, 4, number of (previous, weight) pairs per evaluation; legal range ≥ 1
- SAT_LIMIT, 40.0, magnitude of the sum beyond which the sigmoid output is forced to exactly 1.0 or 0.0
- clk  in  1  single clock; all state updates on its rising edge
- rst  in  1  asynchronous, active-high reset
- fp_start  in  1  begin an evaluation; sampled only in IDLE
- fp_bias  in  real  bias, latched on an accepted fp_start
- fp_in_valid  in  1  fp_previous/fp_weight pair valid
- fp_in_ready  out  1  block accepts a pair this cycle
- fp_previous  in  real  upstream axon value
- fp_weight  in  real  connection weight
- fp_out_valid  out  1  fp_axon and fp_sum valid
- fp_out_ready  in  1  downstream accepts the result
- fp_axon  out  real  registered sigmoid(sum)
- fp_sum  out  real  registered pre-activation sum
- fp_busy  out  1  high in every state except IDLE

## Operation
- States: IDLE, ACCUM, ACT, DONE. Registered state; all outputs are registered or decoded from state.
- IDLE: fp_in_ready=0, fp_out_valid=0. When fp_start=1: acc←fp_bias, count←0, go to ACCUM.
- ACCUM: fp_in_ready=1. On a cycle with fp_in_valid&fp_in_ready: acc←acc+fp_previous·fp_weight, count←count+1. The transfer with count=N_INPUTS-1 moves the block to ACT. Cycles with fp_in_valid=0 hold acc and count.
- ACT: exactly one cycle, fp_in_ready=0. fp_sum←acc. If acc>SAT_LIMIT, fp_axon←1.0. If acc<-SAT_LIMIT, fp_axon←0.0. Otherwise fp_axon←1.0/(1.0+exp(-acc)). Go to DONE.
- DONE: fp_out_valid=1. fp_axon and fp_sum are held stable until fp_out_ready=1, and then the block returns to IDLE. fp_out_ready is ignored in every other state.
- fp_start is ignored outside IDLE. A new fp_start is sampled no earlier than the cycle after DONE exits.
- count width is clog2(N_INPUTS)+1. It never wraps: the evaluation ends at N_INPUTS transfers.
- fp_axon and fp_sum keep their last values after leaving DONE. They change only in ACT or on reset.

## Timing
- Reset (asynchronous, any state): state=IDLE, fp_in_ready=0, fp_out_valid=0, fp_busy=0, fp_axon=0.0, fp_sum=0.0, acc=0.0, count=0. An in-flight evaluation is discarded and no partial result is emitted.
- fp_start is sampled at edge 0. fp_in_ready is high from cycle 1.
- With back-to-back valid, the last pair is accepted at edge N_INPUTS. fp_in_ready drops in cycle N_INPUTS+1 (ACT). fp_out_valid rises in cycle N_INPUTS+2.
- Minimum start-to-result latency is N_INPUTS+2 cycles. Each in_valid bubble adds one cycle.
- Handshake completes at the edge where fp_out_valid&fp_out_ready=1. fp_out_valid is low in the following cycle.
- Minimum evaluation period is N_INPUTS+3 cycles when fp_out_ready is tied high and fp_start is held high.

## Test plan
- N_INPUTS=2, bias 0.0, pairs (1.0,0.5),(1.0,-0.5) back-to-back -> fp_sum=0.0, fp_axon=0.5, fp_out_valid asserted exactly 4 cycles after the start edge.
- N_INPUTS=2, bias 0.5, pairs (2.0,1.0),(0.0,3.0) with a 3-cycle in_valid gap between them -> fp_sum=2.5, fp_axon≈0.924142 (tolerance 1e-6), latency 7 cycles, acc unchanged during the gap.
- Saturation: N_INPUTS=1, bias 0.0, pair (10.0,5.0) -> fp_axon=1.0 exactly. Pair (10.0,-5.0) -> fp_axon=0.0 exactly.
- Backpressure: hold fp_out_ready=0 for 5 cycles in DONE -> fp_out_valid, fp_axon and fp_sum stable for all 5 cycles. Raise fp_out_ready -> IDLE next cycle, fp_busy=0.
- Pulse fp_start during ACCUM and during DONE -> ignored: bias not relatched and the result is unchanged.
- Assert rst mid-ACCUM after 1 of 4 pairs -> immediately fp_in_ready=0, fp_busy=0, fp_axon=0.0. A fresh evaluation afterwards gives a result independent of the discarded pair.

Source files
------------

// File: rtl/forward_propper.sv
// Serial forward-pass neuron: bias plus N streamed input*weight products, then a
// saturating logistic sigmoid, presented on a valid/ready output.
module forward_propper #(
    parameter int  N_INPUTS  = 4,
    parameter real SAT_LIMIT = 40.0
) (
    input  logic clk,
    input  logic rst,
    input  logic fp_start,
    input  real  fp_bias,
    input  logic fp_in_valid,
    output logic fp_in_ready,
    input  real  fp_previous,
    input  real  fp_weight,
    output logic fp_out_valid,
    input  logic fp_out_ready,
    output real  fp_axon,
    output real  fp_sum,
    output logic fp_busy
);

    localparam int CNT_W = $clog2(N_INPUTS) + 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N_INPUTS - 1);

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        ACT,
        DONE
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] count;
    real              acc;
    logic             xfer;

    // Beyond the saturation limit the output is pinned exactly, avoiding exp overflow.
    function automatic real sigmoid_sat(input real x);
        if (x > SAT_LIMIT) begin
            return 1.0;
        end else if (x < -SAT_LIMIT) begin
            return 0.0;
        end else begin
            return 1.0 / (1.0 + $exp(-x));
        end
    endfunction

    assign xfer = fp_in_valid && (state == ACCUM);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        fp_in_ready  = 1'b0;
        fp_out_valid = 1'b0;
        fp_busy      = 1'b1;
        case (state)
            IDLE: begin
                fp_busy = 1'b0;
                if (fp_start) begin
                    state_nxt = ACCUM;
                end
            end
            ACCUM: begin
                fp_in_ready = 1'b1;
                if (fp_in_valid && (count == LAST_IDX)) begin
                    state_nxt = ACT;
                end
            end
            ACT: begin
                state_nxt = DONE;
            end
            DONE: begin
                fp_out_valid = 1'b1;
                if (fp_out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Result registers only move in ACT, so they hold through DONE and afterwards.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc     <= 0.0;
            count   <= '0;
            fp_sum  <= 0.0;
            fp_axon <= 0.0;
        end else begin
            if ((state == IDLE) && fp_start) begin
                acc   <= fp_bias;
                count <= '0;
            end else if (xfer) begin
                acc   <= acc + fp_previous * fp_weight;
                count <= count + 1'b1;
            end
            if (state == ACT) begin
                fp_sum  <= acc;
                fp_axon <= sigmoid_sat(acc);
            end
        end
    end

endmodule
